// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit.
//   state_t       : control state encoding (IDLE, MUL_RUN, DIV_RUN, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of an iteration counter able to hold WIDTH
//   CNT_W         : counter width for the default operand width
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring signed divider datapath, one quotient bit per step.
// Ports:
//   clock    in  : system clock, rising edge
//   load     in  : capture |dividend|, |divisor| and result signs
//   step     in  : perform one shift / trial-subtract iteration
//   dividend in  : signed dividend (rs)
//   divisor  in  : signed divisor (rt), never zero when load is high
//   quo_fix  out : signed quotient of the step in progress, sign applied
//   rem_fix  out : signed remainder of the step in progress, sign applied
// The outputs are only meaningful on the final step; the owner captures
// them on that edge so intermediate values never reach the HI/LO ports.
module div_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_fix,
    output logic [WIDTH-1:0] rem_fix
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // |INT_MIN| wraps to 2^(WIDTH-1), which is still correct read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // The dividend magnitude is shifted out of quo MSB-first while quotient
    // bits are shifted in at the bottom.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs};
    assign fits     = ~trial[WIDTH];
    assign rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

    // Truncating division: quotient negative when signs differ, remainder
    // takes the sign of the dividend.
    assign quo_fix  = q_neg ? -quo_next : quo_next;
    assign rem_fix  = r_neg ? -rem_next : rem_next;

    // NOTE: pure datapath registers carry no reset; load always initialises
    // them before any step reads them, and the control FSM gates their use.
    always_ff @(posedge clock) begin
        if (load) begin
            rem   <= '0;
            quo   <= magnitude(dividend);
            dvs   <= magnitude(divisor);
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end else if (step) begin
            rem   <= rem_next;
            quo   <= quo_next;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiplier/divider (MIPS mult/div semantics).
// Ports:
//   clock   in  : system clock, rising edge
//   Reset   in  : synchronous active-high reset
//   CtoM    in  : start-multiply pulse
//   CtoD    in  : start-divide pulse (CtoM wins if both are high)
//   A, B    in  : operands (multiplicand/multiplier, dividend/divisor)
//   HI, LO  out : mult -> product high/low; div -> remainder/quotient
//   MtoC    out : multiply-done pulse, one cycle
//   DtoC    out : divide-done pulse, one cycle
//   DivZero out : divide-by-zero pulse, one cycle, no operation started
//   busy    out : high while an operation iterates
// Latency: start at edge T, busy for cycles T+1..T+WIDTH, done and valid
// HI/LO in cycle T+WIDTH+1.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             CtoM,
    input  logic             CtoD,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             MtoC,
    output logic             DtoC,
    output logic             DivZero,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            last_step;
    logic            op_div;

    logic            start_mul;
    logic            start_div;
    logic            div_by_zero;

    // Booth accumulator. The upper half carries one extra sign bit so that
    // subtracting an INT_MIN multiplicand cannot overflow.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             q_m1;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   p_hi_next;
    logic [WIDTH-1:0] p_lo_next;

    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign start_mul   = (state == IDLE) && CtoM;
    assign start_div   = (state == IDLE) && !CtoM && CtoD && (B != '0);
    assign div_by_zero = (state == IDLE) && !CtoM && CtoD && (B == '0);
    assign last_step   = (count == CW'(WIDTH - 1));

    assign busy = (state == MUL_RUN) || (state == DIV_RUN);
    assign MtoC = (state == DONE) && !op_div;
    assign DtoC = (state == DONE) && op_div;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_mul)      state_next = MUL_RUN;
                else if (start_div) state_next = DIV_RUN;
            end
            MUL_RUN, DIV_RUN: begin
                if (last_step) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control registers and the architecturally visible HI/LO.
    always_ff @(posedge clock) begin
        if (Reset) begin
            count   <= '0;
            op_div  <= 1'b0;
            DivZero <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            DivZero <= div_by_zero;
            if (start_mul || start_div) begin
                count  <= '0;
                op_div <= start_div;
            end else if (busy) begin
                count  <= count + 1'b1;
            end
            if (last_step && state == MUL_RUN) begin
                HI <= p_hi_next[WIDTH-1:0];
                LO <= p_lo_next;
            end else if (last_step && state == DIV_RUN) begin
                HI <= rem_fix;
                LO <= quo_fix;
            end
        end
    end

    // Radix-2 Booth step: examine {P_lo[0], q_-1}, add/subtract the
    // multiplicand into the upper half, then arithmetic shift right by one.
    always_comb begin
        sum = p_hi;
        unique case ({p_lo[0], q_m1})
            2'b01:   sum = p_hi + {mcand[WIDTH-1], mcand};
            2'b10:   sum = p_hi - {mcand[WIDTH-1], mcand};
            default: sum = p_hi;
        endcase
    end

    assign p_hi_next = {sum[WIDTH], sum[WIDTH:1]};
    assign p_lo_next = {sum[0], p_lo[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (start_mul) begin
            mcand <= A;
            p_hi  <= '0;
            p_lo  <= B;
            q_m1  <= 1'b0;
        end else if (state == MUL_RUN) begin
            p_hi  <= p_hi_next;
            p_lo  <= p_lo_next;
            q_m1  <= p_lo[0];
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clock    (clock),
        .load     (start_div),
        .step     (state == DIV_RUN),
        .dividend (A),
        .divisor  (B),
        .quo_fix  (quo_fix),
        .rem_fix  (rem_fix)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// randomized operations, checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         Reset;
    logic         CtoM;
    logic         CtoD;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         MtoC;
    logic         DtoC;
    logic         DivZero;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Reference architectural HI/LO.
    logic [W-1:0] mdl_hi;
    logic [W-1:0] mdl_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .Reset   (Reset),
        .CtoM    (CtoM),
        .CtoD    (CtoD),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .MtoC    (MtoC),
        .DtoC    (DtoC),
        .DivZero (DivZero),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] status();
        return {busy, MtoC, DtoC, DivZero};
    endfunction

    // op: 0 = mult, 1 = div, 2 = CtoM and CtoD together (mult must win).
    // interfere_at: cycle index (after the start edge) at which extra start
    // pulses with fresh operands are applied; 0 disables.
    task automatic do_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int interfere_at);
        bit           is_div;
        longint       sa;
        longint       sb;
        longint       prod;
        longint       q;
        longint       r;
        logic [63:0]  pv;
        logic [63:0]  qv;
        logic [63:0]  rv;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;

        is_div = (op == 1);
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (is_div && b != '0) begin
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            exp_lo = qv[W-1:0];
            exp_hi = rv[W-1:0];
        end else begin
            prod = sa * sb;
            pv   = prod;
            exp_hi = pv[63:32];
            exp_lo = pv[31:0];
        end

        CtoM = (op != 1);
        CtoD = (op != 0);
        A = a;
        B = b;
        tick();
        CtoM = 1'b0;
        CtoD = 1'b0;
        A = $urandom;
        B = $urandom;

        if (is_div && b == '0) begin
            check("divzero_pulse", 64'(status()), 64'b0001);
            check("divzero_hi", 64'(HI), 64'(mdl_hi));
            check("divzero_lo", 64'(LO), 64'(mdl_lo));
            tick();
            check("divzero_after", 64'(status()), 64'b0000);
            check("divzero_hi2", 64'(HI), 64'(mdl_hi));
            return;
        end

        for (int cyc = 1; cyc <= W; cyc++) begin
            if (cyc > 1) begin
                tick();
                CtoM = 1'b0;
                CtoD = 1'b0;
            end
            if (cyc == interfere_at) begin
                CtoM = 1'b1;
                CtoD = 1'b1;
                A = $urandom;
                B = $urandom;
            end
            check("run_status", 64'(status()), 64'b1000);
            check("run_hold_hi", 64'(HI), 64'(mdl_hi));
            check("run_hold_lo", 64'(LO), 64'(mdl_lo));
        end

        tick();
        CtoM = 1'b0;
        CtoD = 1'b0;
        check(is_div ? "div_done" : "mul_done", 64'(status()), is_div ? 64'b0010 : 64'b0100);
        check(is_div ? "div_hi" : "mul_hi", 64'(HI), 64'(exp_hi));
        check(is_div ? "div_lo" : "mul_lo", 64'(LO), 64'(exp_lo));
        mdl_hi = exp_hi;
        mdl_lo = exp_lo;
        tick();
        check("post_done_status", 64'(status()), 64'b0000);
        check("post_done_hi", 64'(HI), 64'(mdl_hi));
        check("post_done_lo", 64'(LO), 64'(mdl_lo));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           op;
        bit           saw_done;

        Reset = 1'b1;
        CtoM  = 1'b0;
        CtoD  = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("reset_status", 64'(status()), 64'b0000);
        check("reset_hi", 64'(HI), 64'h0);
        check("reset_lo", 64'(LO), 64'h0);
        Reset  = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;

        // Directed cases.
        do_op(0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7x-3_hi", 64'(mdl_hi), 64'hFFFF_FFFF);
        check("mul_7x-3_lo", 64'(LO), 64'hFFFF_FFEB);
        do_op(1, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_-7/2_lo", 64'(LO), 64'hFFFF_FFFD);
        check("div_-7/2_hi", 64'(HI), 64'hFFFF_FFFF);
        do_op(1, 32'd100, 32'd7, 0);
        check("div_100/7_lo", 64'(LO), 64'd14);
        check("div_100/7_hi", 64'(HI), 64'd2);
        do_op(1, 32'd5, 32'd0, 0);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_intmin_lo", 64'(LO), 64'h8000_0000);
        check("div_intmin_hi", 64'(HI), 64'h0);
        do_op(0, 32'h8000_0000, 32'h8000_0000, 0);
        check("mul_intmin_hi", 64'(HI), 64'h4000_0000);
        check("mul_intmin_lo", 64'(LO), 64'h0);
        do_op(2, 32'd12345, 32'hFFFF_0000, 0);

        // Start pulses during a running multiply must be ignored.
        do_op(0, 32'h1234_5678, 32'hFEDC_BA98, 10);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done |= DtoC | MtoC | busy;
        end
        check("ignored_start_no_followup", 64'(saw_done), 64'b0);

        // Reset in the middle of a divide aborts it silently.
        CtoD = 1'b1;
        A = 32'd1000;
        B = 32'd3;
        tick();
        CtoD = 1'b0;
        for (int cyc = 2; cyc <= 15; cyc++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_status", 64'(status()), 64'b0000);
        check("abort_hi", 64'(HI), 64'h0);
        check("abort_lo", 64'(LO), 64'h0);
        mdl_hi = '0;
        mdl_lo = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done |= DtoC | MtoC;
        end
        check("abort_no_done", 64'(saw_done), 64'b0);
        do_op(0, 32'hFFFF_FFFF, 32'd9, 0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = W'(int'($urandom_range(0, 15)) - 8);
                2:       rb = {1'b1, 31'($urandom)};
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            do_op(op, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
